cpu16_regctl: RTL and testbench

//  Register-file controller between the cpu16 core and its 8x16 two-read/one-write regfile.
//  - Clears all 8 registers after reset, because the block-RAM banks have no reset.
//  - Shares the regfile ports between the core and a debug/loader port.
//  - Handles the 1-cycle registered read latency of the regfile.

---
 rtl/cpu16_regctl.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu16_regctl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu16_regctl.sv
// ---------------------------------------------------------------------------
// cpu16_regctl
//
// Register-file controller that sits between the cpu16 core and its 8x16
// two-read/one-write register file (block RAM, registered reads, no reset).
//
// Responsibilities:
//   - After reset, sweep r0..r7 with INIT_VALUE. The RAM banks have no reset
//     of their own, so this sweep is what clears them.
//   - Share the regfile ports between the core and a debug/loader port.
//   - Hide the 1-cycle registered read latency of the regfile from the
//     debug port.
//
// Parameters:
//   INIT_VALUE    value written to every register during the init sweep
//   DBG_WAIT_MAX  cycles a debug write waits behind core writes before it
//                 forces a one-cycle core stall (legal range 1..15)
//
// Configuration macro:
//   REGS_BYPASS_EN  when defined, a read of the register being written in
//                   the same cycle returns the new data one cycle later.
//                   When undefined, reads return whatever the regfile
//                   returns (old data on the BRAM build).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   core_asel/bsel                 core read addresses (data 1 cycle later)
//   core_wsel/wreg/wdata           core write port
//   core_adata/bdata               core read data
//   core_stall                     core must hold its inputs
//   init_done                      init sweep complete
//   dbg_req/we/addr/wdata          debug request (held until dbg_ack)
//   dbg_ack                        1-cycle completion pulse
//   dbg_rdata                      debug read data, valid with ack, held
//   rf_asel/bsel/wsel/wreg/wdata   regfile address/write side
//   rf_adata/bdata                 regfile registered read data
// ---------------------------------------------------------------------------
module cpu16_regctl #(
  parameter logic [15:0] INIT_VALUE   = 16'h0000,
  parameter int          DBG_WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [2:0]  core_asel,
  input  logic [2:0]  core_bsel,
  input  logic [2:0]  core_wsel,
  input  logic        core_wreg,
  input  logic [15:0] core_wdata,
  output logic [15:0] core_adata,
  output logic [15:0] core_bdata,
  output logic        core_stall,
  output logic        init_done,

  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [2:0]  dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [15:0] dbg_rdata,

  output logic [2:0]  rf_asel,
  output logic [2:0]  rf_bsel,
  output logic [2:0]  rf_wsel,
  output logic        rf_wreg,
  output logic [15:0] rf_wdata,
  input  logic [15:0] rf_adata,
  input  logic [15:0] rf_bdata
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DRD
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(DBG_WAIT_MAX);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [3:0]  waitcnt, waitcnt_nxt;
  logic        ack_q, ack_nxt;
  logic [15:0] rdata_q, rdata_nxt;
  logic        rf_wreg_int;

  // Read data as seen by the controller after the optional bypass.
  logic [15:0] a_rd;
  logic [15:0] b_rd;

  // State and bookkeeping registers. The debug read data register and the
  // ack pulse are cleared here so a reset in the middle of a debug read
  // drops the transaction without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      cnt     <= 3'd0;
      waitcnt <= 4'd0;
      ack_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      waitcnt <= waitcnt_nxt;
      ack_q   <= ack_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  // Next-state and port-steering logic.
  // In RUN the regfile ports follow the core unless a debug request wins:
  //   - debug read steals port A for one cycle (core stalled, its write
  //     still goes through), the data returns in DRD;
  //   - debug write waits for a cycle without a core write, or after
  //     WAIT_LIMIT blocked cycles takes the write port by stalling the core
  //     and dropping that cycle's core write.
  // A request is ignored in the cycle that carries the ack for the previous
  // one, so a requester that keeps dbg_req high cannot be acked twice for
  // the same handshake.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    waitcnt_nxt = waitcnt;
    ack_nxt     = 1'b0;
    rdata_nxt   = rdata_q;
    rf_asel     = core_asel;
    rf_bsel     = core_bsel;
    rf_wsel     = core_wsel;
    rf_wdata    = core_wdata;
    rf_wreg_int = 1'b0;
    core_stall  = 1'b1;
    dbg_rdata   = rdata_q;

    case (state)
      ST_INIT: begin
        rf_wsel     = cnt;
        rf_wdata    = INIT_VALUE;
        rf_wreg_int = 1'b1;
        cnt_nxt     = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        core_stall  = 1'b0;
        rf_wreg_int = core_wreg;
        if (dbg_req && !ack_q) begin
          if (!dbg_we) begin
            rf_asel     = dbg_addr;
            core_stall  = 1'b1;
            waitcnt_nxt = 4'd0;
            ack_nxt     = 1'b1;
            state_nxt   = ST_DRD;
          end else if (!core_wreg || (waitcnt == WAIT_LIMIT)) begin
            // A forced grant stalls the core; a free one does not.
            core_stall  = core_wreg;
            rf_wsel     = dbg_addr;
            rf_wdata    = dbg_wdata;
            rf_wreg_int = 1'b1;
            waitcnt_nxt = 4'd0;
            ack_nxt     = 1'b1;
          end else begin
            waitcnt_nxt = waitcnt + 4'd1;
          end
        end else if (!dbg_req) begin
          waitcnt_nxt = 4'd0;
        end
      end

      ST_DRD: begin
        // Port A data belongs to the debug port this cycle; it is shown
        // directly with the ack and captured for later.
        dbg_rdata = a_rd;
        rdata_nxt = a_rd;
        state_nxt = ST_RUN;
      end

      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // The regfile write enable is gated by reset directly so nothing is
  // written into the RAM while rst_n is low, whatever the state register
  // is doing.
  assign rf_wreg = rf_wreg_int & rst_n;

`ifdef REGS_BYPASS_EN
  logic        byp_a;
  logic        byp_b;
  logic [15:0] byp_data;

  // Remember same-cycle read/write collisions so the next cycle can return
  // the freshly written value instead of the regfile's old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_a    <= 1'b0;
      byp_b    <= 1'b0;
      byp_data <= 16'h0000;
    end else begin
      byp_a    <= rf_wreg && (rf_asel == rf_wsel);
      byp_b    <= rf_wreg && (rf_bsel == rf_wsel);
      byp_data <= rf_wdata;
    end
  end

  assign a_rd = byp_a ? byp_data : rf_adata;
  assign b_rd = byp_b ? byp_data : rf_bdata;
`else
  assign a_rd = rf_adata;
  assign b_rd = rf_bdata;
`endif

  assign core_adata = a_rd;
  assign core_bdata = b_rd;
  assign dbg_ack    = ack_q;
  assign init_done  = (state != ST_INIT);

endmodule

// File: tb/tb_cpu16_regctl.sv
// ---------------------------------------------------------------------------
// tb_cpu16_regctl
//
// Bench for cpu16_regctl. A behavioural BRAM (registered reads, old data on
// collision) sits on the rf_* side. The reference model is an architectural
// register array plus the handshake timing rules of the controller.
// ---------------------------------------------------------------------------
module tb_cpu16_regctl;

  localparam logic [15:0] INITV = 16'h0000;
  localparam int          WMAX  = 4;
`ifdef REGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [2:0]  core_asel, core_bsel, core_wsel;
  logic        core_wreg;
  logic [15:0] core_wdata;
  logic [15:0] core_adata, core_bdata;
  logic        core_stall, init_done;
  logic        dbg_req, dbg_we;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;
  logic [2:0]  rf_asel, rf_bsel, rf_wsel;
  logic        rf_wreg;
  logic [15:0] rf_wdata;
  logic [15:0] rf_adata, rf_bdata;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem     [8];
  logic [15:0] exp_reg [8];
  logic        pend_valid;
  logic [15:0] pend_a, pend_b;

  typedef struct {
    logic        wreg;
    logic [2:0]  wsel;
    logic [15:0] wdata;
    logic [2:0]  asel;
    logic [2:0]  bsel;
    logic        chk;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  cpu16_regctl #(
    .INIT_VALUE  (INITV),
    .DBG_WAIT_MAX(WMAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core_asel (core_asel),
    .core_bsel (core_bsel),
    .core_wsel (core_wsel),
    .core_wreg (core_wreg),
    .core_wdata(core_wdata),
    .core_adata(core_adata),
    .core_bdata(core_bdata),
    .core_stall(core_stall),
    .init_done (init_done),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .rf_asel   (rf_asel),
    .rf_bsel   (rf_bsel),
    .rf_wsel   (rf_wsel),
    .rf_wreg   (rf_wreg),
    .rf_wdata  (rf_wdata),
    .rf_adata  (rf_adata),
    .rf_bdata  (rf_bdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural block RAM: registered reads, read-before-write.
  always @(posedge clk) begin
    rf_adata <= mem[rf_asel];
    rf_bdata <= mem[rf_bsel];
    if (rf_wreg) mem[rf_wsel] <= rf_wdata;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic wreg, input logic [2:0] wsel,
                               input logic [15:0] wdata, input logic [2:0] asel,
                               input logic [2:0] bsel, input logic req,
                               input logic we, input logic [2:0] daddr,
                               input logic [15:0] dwdata);
    core_wreg  = wreg;
    core_wsel  = wsel;
    core_wdata = wdata;
    core_asel  = asel;
    core_bsel  = bsel;
    dbg_req    = req;
    dbg_we     = we;
    dbg_addr   = daddr;
    dbg_wdata  = dwdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Init sweep after reset release: 8 write cycles r0..r7, then RUN.
  task automatic initSweep(input logic dreq);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, (i < 8) ? dreq : 1'b0,
                    1'b0, 3'd6, 16'h0);
      @(negedge clk);
      if (i < 8) begin
        checkOutput("init_wreg", 16'(rf_wreg), 16'd1);
        checkOutput("init_wsel", 16'(rf_wsel), 16'(i));
        checkOutput("init_wdata", rf_wdata, INITV);
        checkOutput("init_stall", 16'(core_stall), 16'd1);
        checkOutput("init_done_low", 16'(init_done), 16'd0);
      end else begin
        checkOutput("init_done_high", 16'(init_done), 16'd1);
        checkOutput("run_stall", 16'(core_stall), 16'd0);
      end
      checkOutput("init_no_ack", 16'(dbg_ack), 16'd0);
      nextCycle();
    end
    for (int r = 0; r < 8; r++) exp_reg[r] = INITV;
    pend_valid = 1'b0;
  endtask

  // Plain core cycle, no debug traffic.
  task automatic coreCycle(input logic wreg, input logic [2:0] wsel,
                           input logic [15:0] wdata, input logic [2:0] asel,
                           input logic [2:0] bsel);
    applyStimulus(wreg, wsel, wdata, asel, bsel, 1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    checkOutput("core_stall_idle", 16'(core_stall), 16'd0);
    checkOutput("dbg_ack_idle", 16'(dbg_ack), 16'd0);
    if (pend_valid) begin
      checkOutput("core_adata", core_adata, pend_a);
      checkOutput("core_bdata", core_bdata, pend_b);
    end
    pend_a = (BYP && wreg && (wsel == asel)) ? wdata : exp_reg[asel];
    pend_b = (BYP && wreg && (wsel == bsel)) ? wdata : exp_reg[bsel];
    pend_valid = 1'b1;
    if (wreg) exp_reg[wsel] = wdata;
    nextCycle();
  endtask

  // Debug read; the core may write in the grant cycle and holds in DRD.
  task automatic dbgRead(input logic [2:0] addr, input logic wreg,
                         input logic [2:0] wsel, input logic [15:0] wdata);
    logic [15:0] expd;
    applyStimulus(wreg, wsel, wdata, 3'd0, 3'd1, 1'b1, 1'b0, addr, 16'h0);
    @(negedge clk);
    checkOutput("drd_grant_stall", 16'(core_stall), 16'd1);
    checkOutput("drd_grant_asel", 16'(rf_asel), 16'(addr));
    checkOutput("drd_grant_noack", 16'(dbg_ack), 16'd0);
    if (pend_valid) checkOutput("core_adata_pre_drd", core_adata, pend_a);
    expd = (BYP && wreg && (wsel == addr)) ? wdata : exp_reg[addr];
    if (wreg) exp_reg[wsel] = wdata;
    nextCycle();
    @(negedge clk);
    checkOutput("drd_stall", 16'(core_stall), 16'd1);
    checkOutput("drd_ack", 16'(dbg_ack), 16'd1);
    checkOutput("drd_rdata", dbg_rdata, expd);
    nextCycle();
    pend_valid = 1'b0;
    coreCycle(1'b0, 3'd0, 16'h0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    checkOutput("drd_rdata_held", dbg_rdata, expd);
  endtask

  // Debug write while the core writes for k consecutive cycles.
  task automatic dbgWrite(input logic [2:0] addr, input logic [15:0] data,
                          input int k, input logic same_addr);
    int g;
    logic forced;
    logic wr;
    logic [2:0] ws;
    logic [15:0] wd;
    g      = (k <= WMAX) ? k : WMAX;
    forced = (k > WMAX);
    for (int i = 0; i <= g + 1; i++) begin
      wr = (i < k);
      ws = same_addr ? addr : 3'($urandom_range(0, 7));
      wd = same_addr ? ((i == g) ? 16'hDEAD : 16'hC000 + 16'(i)) : 16'($urandom);
      applyStimulus(wr, ws, wd, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    1'b1, 1'b1, addr, data);
      @(negedge clk);
      checkOutput("dwr_ack", 16'(dbg_ack), 16'(i == g + 1));
      checkOutput("dwr_stall", 16'(core_stall), 16'((i == g) && forced));
      if (i == g) begin
        checkOutput("dwr_grant_wreg", 16'(rf_wreg), 16'd1);
        checkOutput("dwr_grant_wsel", 16'(rf_wsel), 16'(addr));
        checkOutput("dwr_grant_wdata", rf_wdata, data);
        exp_reg[addr] = data;
      end else if (i < g) begin
        checkOutput("dwr_blocked_wreg", 16'(rf_wreg), 16'(wr));
        if (wr) exp_reg[ws] = wd;
      end
      nextCycle();
    end
    dbg_req    = 1'b0;
    pend_valid = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 8; r++) mem[r] = 16'hDEAD ^ 16'(r * 16'h1111);
    rf_adata   = 16'hBAD0;
    rf_bdata   = 16'hBAD1;
    pend_valid = 1'b0;
    pend_a     = 16'h0;
    pend_b     = 16'h0;
    for (int r = 0; r < 8; r++) exp_reg[r] = 16'h0;

    vecs[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd1, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd4, 1'b1, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b1, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 3'd1, 16'h0F0F, 3'd1, 3'd2, 1'b1, 16'hBEEF, 16'hBEEF};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd3, 1'b1,
                (BYP ? 16'h0F0F : 16'h0000), 16'h0000};
    vecs[5] = '{1'b1, 3'd7, 16'h7777, 3'd6, 3'd7, 1'b1, 16'h0F0F, 16'hBEEF};
    vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd0, 1'b1,
                16'h0000, (BYP ? 16'h7777 : 16'h0000)};
    vecs[7] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b1, 16'h7777, 16'h0000};

    // Reset state, then the init sweep with a debug request that must be ignored.
    rst_n = 1'b0;
    applyStimulus(1'b1, 3'd2, 16'h5555, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", 16'(core_stall), 16'd1);
    checkOutput("rst_init_done", 16'(init_done), 16'd0);
    checkOutput("rst_ack", 16'(dbg_ack), 16'd0);
    checkOutput("rst_rdata", dbg_rdata, 16'h0000);
    checkOutput("rst_wreg", 16'(rf_wreg), 16'd0);
    nextCycle();
    rst_n = 1'b1;
    initSweep(1'b1);

    // Table-driven core traffic: write/read-back and same-cycle collisions.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].wreg, vecs[v].wsel, vecs[v].wdata, vecs[v].asel,
                    vecs[v].bsel, 1'b0, 1'b0, 3'd0, 16'h0);
      @(negedge clk);
      checkOutput("vec_stall", 16'(core_stall), 16'd0);
      if (vecs[v].chk) begin
        checkOutput($sformatf("vec%0d_adata", v), core_adata, vecs[v].exp_a);
        checkOutput($sformatf("vec%0d_bdata", v), core_bdata, vecs[v].exp_b);
      end
      if (vecs[v].wreg) exp_reg[vecs[v].wsel] = vecs[v].wdata;
      nextCycle();
    end
    pend_valid = 1'b0;

    // Debug read of r5 holding 16'h1234.
    coreCycle(1'b1, 3'd5, 16'h1234, 3'd0, 3'd0);
    coreCycle(1'b0, 3'd0, 16'h0, 3'd5, 3'd5);
    dbgRead(3'd5, 1'b0, 3'd0, 16'h0);
    checkOutput("r5_dbg_const", dbg_rdata, 16'h1234);

    // Debug write r2 against a core that writes r2 every cycle.
    dbgWrite(3'd2, 16'hA5A5, WMAX + 1, 1'b1);
    coreCycle(1'b0, 3'd0, 16'h0, 3'd2, 3'd2);
    @(negedge clk);
    checkOutput("r2_after_dbg_write", core_adata, 16'hA5A5);
    nextCycle();
    pend_valid = 1'b0;

    // Requester holding dbg_req high: served every second cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, (i < 4), 1'b1, 3'd4, 16'h4444);
      @(negedge clk);
      checkOutput("b2b_ack", 16'(dbg_ack), 16'(i % 2 == 1));
      checkOutput("b2b_wreg", 16'(rf_wreg), 16'((i < 4) && (i % 2 == 0)));
      nextCycle();
    end
    exp_reg[4] = 16'h4444;
    dbg_req = 1'b0;

    // Reset asserted during the DRD cycle of a debug read.
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd5, 16'h0);
    @(negedge clk);
    checkOutput("rst_drd_grant_stall", 16'(core_stall), 16'd1);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_drd_ack", 16'(dbg_ack), 16'd0);
    checkOutput("rst_drd_rdata", dbg_rdata, 16'h0000);
    checkOutput("rst_drd_stall", 16'(core_stall), 16'd1);
    checkOutput("rst_drd_wreg", 16'(rf_wreg), 16'd0);
    nextCycle();
    rst_n = 1'b1;
    initSweep(1'b0);

    // Randomized mix checked against the architectural model.
    for (int t = 0; t < 250; t++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 6) begin
        coreCycle(1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end else if (sel == 7) begin
        dbgRead(3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom_range(0, 7)),
                16'($urandom));
      end else begin
        dbgWrite(3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, WMAX + 1), 1'($urandom));
      end
    end

    // Final read-back of every register through the core ports.
    for (int r = 0; r < 8; r++) begin
      coreCycle(1'b0, 3'd0, 16'h0, 3'(r), 3'(7 - r));
    end
    coreCycle(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
